// File: rtl/mem_access_unit_if.sv
// Data bus between the MEM-stage load/store engine and the memory slave.
// req/addr_ok hand off a request, data_ok returns read data or a write ack.
interface mem_access_unit_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one bus access per memory instruction,
// stalls the pipeline while it is outstanding, formats load results and store
// strobes, and keeps the bus consistent when the instruction is flushed.
//
// state | meaning
// IDLE  | no access in flight; decode, ALE detection, passthrough writeback
// REQ   | request on the bus, waiting for addr_ok
// WAIT  | request accepted, waiting for data_ok
// DONE  | result valid for one cycle, pipeline released
// DRAIN | flushed access still owes a data_ok; absorb it before reissuing
module mem_access_unit #(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exception_flush,
  input  logic [3:0]        mem_op,
  input  logic [31:0]       mem_mem_addr,
  input  logic [31:0]       mem_store_data,
  input  logic [31:0]       mem_reg_write_data,
  input  logic [4:0]        mem_reg_write_addr,
  input  logic              mem_reg_write_en,
  mem_access_unit_if.master dbus,
  output logic              pause_req,
  output logic [31:0]       wb_reg_write_data,
  output logic [4:0]        wb_reg_write_addr,
  output logic              wb_reg_write_en,
  output logic              ale_exception,
  output logic [31:0]       bad_vaddr
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [3:0] OP_LD_B  = 4'd1;
  localparam logic [3:0] OP_LD_H  = 4'd2;
  localparam logic [3:0] OP_LD_W  = 4'd3;
  localparam logic [3:0] OP_LD_BU = 4'd4;
  localparam logic [3:0] OP_LD_HU = 4'd5;
  localparam logic [3:0] OP_ST_B  = 4'd6;
  localparam logic [3:0] OP_ST_H  = 4'd7;
  localparam logic [3:0] OP_ST_W  = 4'd8;

  state_t      state;
  state_t      state_next;
  logic [31:0] load_buf;

  logic        is_load;
  logic        is_store;
  logic        mem_valid;
  logic        misaligned;
  logic [1:0]  acc_size;

  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;

  // Decode the operation into load/store class and access size.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    acc_size = 2'd0;
    case (mem_op)
      OP_LD_B, OP_LD_BU: begin is_load  = 1'b1; acc_size = 2'd0; end
      OP_LD_H, OP_LD_HU: begin is_load  = 1'b1; acc_size = 2'd1; end
      OP_LD_W:           begin is_load  = 1'b1; acc_size = 2'd2; end
      OP_ST_B:           begin is_store = 1'b1; acc_size = 2'd0; end
      OP_ST_H:           begin is_store = 1'b1; acc_size = 2'd1; end
      OP_ST_W:           begin is_store = 1'b1; acc_size = 2'd2; end
      default: ;
    endcase
    mem_valid  = is_load | is_store;
    misaligned = ALIGN_CHECK &&
                 (((acc_size == 2'd1) && mem_mem_addr[0]) ||
                  ((acc_size == 2'd2) && (mem_mem_addr[1:0] != 2'b00)));
  end

  // State register; reset abandons any access since the slave resets too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Capture read data only for an access that survives to completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      load_buf <= 32'd0;
    else if ((state == WAIT) && dbus.data_ok && !exception_flush)
      load_buf <= dbus.rdata;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (mem_valid && !misaligned && !exception_flush) state_next = REQ;
      REQ: begin
        if (exception_flush)   state_next = IDLE;
        else if (dbus.addr_ok) state_next = WAIT;
      end
      WAIT: begin
        if (dbus.data_ok && exception_flush) state_next = IDLE;
        else if (dbus.data_ok)               state_next = DONE;
        else if (exception_flush)            state_next = DRAIN;
      end
      DONE:  state_next = IDLE;
      DRAIN: if (dbus.data_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stall request, ALE and bus request fields.
  always_comb begin
    pause_req = 1'b0;
    case (state)
      IDLE:      pause_req = mem_valid && !misaligned && !exception_flush;
      REQ, WAIT: pause_req = 1'b1;
      DRAIN:     pause_req = mem_valid;
      default:   pause_req = 1'b0;
    endcase

    ale_exception = (state == IDLE) && mem_valid && misaligned && !exception_flush;
    bad_vaddr     = ale_exception ? mem_mem_addr : 32'd0;

    bus_req   = (state == REQ);
    bus_wr    = 1'b0;
    bus_size  = 2'd0;
    bus_addr  = 32'd0;
    bus_wstrb = 4'b0000;
    bus_wdata = 32'd0;
    if (bus_req) begin
      bus_wr   = is_store;
      bus_size = acc_size;
      bus_addr = mem_mem_addr;
      case (mem_op)
        OP_ST_B: begin
          bus_wstrb = 4'b0001 << mem_mem_addr[1:0];
          bus_wdata = {4{mem_store_data[7:0]}};
        end
        OP_ST_H: begin
          bus_wstrb = mem_mem_addr[1] ? 4'b1100 : 4'b0011;
          bus_wdata = {2{mem_store_data[15:0]}};
        end
        OP_ST_W: begin
          bus_wstrb = 4'b1111;
          bus_wdata = mem_store_data;
        end
        default: ;
      endcase
    end
  end

  // Load extraction and writeback selection.
  always_comb begin
    ld_byte   = load_buf[{mem_mem_addr[1:0], 3'b000} +: 8];
    ld_half   = load_buf[{mem_mem_addr[1], 4'b0000} +: 16];
    ld_result = load_buf;
    case (mem_op)
      OP_LD_B:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      OP_LD_BU: ld_result = {24'd0, ld_byte};
      OP_LD_H:  ld_result = {{16{ld_half[15]}}, ld_half};
      OP_LD_HU: ld_result = {16'd0, ld_half};
      default:  ld_result = load_buf;
    endcase

    wb_reg_write_data = ((state == DONE) && is_load) ? ld_result : mem_reg_write_data;
    wb_reg_write_addr = mem_reg_write_addr;
    wb_reg_write_en   = mem_reg_write_en && !pause_req && !ale_exception && !exception_flush;
  end

  assign dbus.req   = bus_req;
  assign dbus.wr    = bus_wr;
  assign dbus.size  = bus_size;
  assign dbus.addr  = bus_addr;
  assign dbus.wstrb = bus_wstrb;
  assign dbus.wdata = bus_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expected bus
// requests, writebacks and ALEs; a negedge monitor pops and compares them.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        exception_flush;
  logic [3:0]  mem_op;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_store_data;
  logic [31:0] mem_reg_write_data;
  logic [4:0]  mem_reg_write_addr;
  logic        mem_reg_write_en;
  logic        pause_req;
  logic [31:0] wb_reg_write_data;
  logic [4:0]  wb_reg_write_addr;
  logic        wb_reg_write_en;
  logic        ale_exception;
  logic [31:0] bad_vaddr;

  mem_access_unit_if dbus();

  mem_access_unit #(.ALIGN_CHECK(1'b1)) dut (
    .clk                (clk),
    .rst                (rst),
    .exception_flush    (exception_flush),
    .mem_op             (mem_op),
    .mem_mem_addr       (mem_mem_addr),
    .mem_store_data     (mem_store_data),
    .mem_reg_write_data (mem_reg_write_data),
    .mem_reg_write_addr (mem_reg_write_addr),
    .mem_reg_write_en   (mem_reg_write_en),
    .dbus               (dbus),
    .pause_req          (pause_req),
    .wb_reg_write_data  (wb_reg_write_data),
    .wb_reg_write_addr  (wb_reg_write_addr),
    .wb_reg_write_en    (wb_reg_write_en),
    .ale_exception      (ale_exception),
    .bad_vaddr          (bad_vaddr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  req_t        exp_req[$];
  wb_t         exp_wb[$];
  logic [31:0] exp_ale[$];

  int checks = 0;
  int passes = 0;
  int pause_drops = 0;
  bit in_access = 1'b0;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic unexpected(input string name, input logic [95:0] got);
    checks++;
    $display("FAIL %s: got event %0h, expected none", name, got);
  endtask

  // Monitor: compare every accepted request, writeback and ALE against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (dbus.req && dbus.addr_ok) begin
        if (exp_req.size() == 0) unexpected("bus_req", {dbus.wr, dbus.addr});
        else begin
          req_t e;
          req_t a;
          e = exp_req.pop_front();
          a = '{wr: dbus.wr, size: dbus.size, addr: dbus.addr, wstrb: dbus.wstrb,
                wdata: e.wr ? dbus.wdata : 32'd0};
          check("bus_req", a, e);
        end
      end
      if (wb_reg_write_en) begin
        if (exp_wb.size() == 0) unexpected("wb", {wb_reg_write_addr, wb_reg_write_data});
        else check("wb", {wb_reg_write_addr, wb_reg_write_data}, exp_wb.pop_front());
      end
      if (ale_exception) begin
        if (exp_ale.size() == 0) unexpected("ale", bad_vaddr);
        else check("ale_vaddr", bad_vaddr, exp_ale.pop_front());
      end
      if (in_access && !pause_req) pause_drops++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] wdata, input logic [4:0] rd, input logic en);
    mem_op             = op;
    mem_mem_addr       = addr;
    mem_store_data     = sdata;
    mem_reg_write_data = wdata;
    mem_reg_write_addr = rd;
    mem_reg_write_en   = en;
  endtask

  task automatic nop();
    drive(4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  // One complete access: addr_ok a_dly cycles into REQ, data_ok d_dly cycles into WAIT.
  task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input logic en, input int a_dly, input int d_dly,
                        input logic [31:0] rdata, input logic exp_wr, input logic [1:0] exp_size,
                        input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_wbdata);
    exp_req.push_back('{wr: exp_wr, size: exp_size, addr: addr, wstrb: exp_wstrb, wdata: exp_wdata});
    if (en) exp_wb.push_back('{rd: rd, data: exp_wbdata});
    drive(op, addr, sdata, 32'h5A5A5A5A, rd, en);
    in_access = 1'b1;
    pause_drops = 0;
    tick();
    check("req_up", dbus.req, 1'b1);
    repeat (a_dly) tick();
    dbus.addr_ok = 1'b1;
    tick();
    dbus.addr_ok = 1'b0;
    repeat (d_dly) tick();
    dbus.data_ok = 1'b1;
    dbus.rdata   = rdata;
    tick();
    dbus.data_ok = 1'b0;
    dbus.rdata   = 32'd0;
    in_access = 1'b0;
    @(negedge clk);
    check("done_pause", pause_req, 1'b0);
    check("pause_held", pause_drops, 0);
    tick();
    nop();
  endtask

  initial begin
    rst = 1'b1;
    exception_flush = 1'b0;
    dbus.addr_ok = 1'b0;
    dbus.data_ok = 1'b0;
    dbus.rdata   = 32'd0;
    nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {dbus.req, dbus.addr, dbus.wstrb, pause_req, wb_reg_write_en, ale_exception, bad_vaddr, wb_reg_write_data},
          '0);
    tick();
    rst = 1'b0;
    tick();

    // Loads and stores with formatting.
    access(4'd3, 32'h1C000100, 32'd0,        5'd3, 1'b1, 2, 2, 32'h89ABCDEF, 1'b0, 2'd2, 4'h0, 32'd0,        32'h89ABCDEF);
    access(4'd1, 32'h1C000103, 32'd0,        5'd4, 1'b1, 0, 0, 32'h80000000, 1'b0, 2'd0, 4'h0, 32'd0,        32'hFFFFFF80);
    access(4'd4, 32'h1C000103, 32'd0,        5'd4, 1'b1, 1, 0, 32'h80000000, 1'b0, 2'd0, 4'h0, 32'd0,        32'h00000080);
    access(4'd7, 32'h1C000102, 32'h0000BEEF, 5'd0, 1'b0, 0, 1, 32'd0,        1'b1, 2'd1, 4'hC, 32'hBEEFBEEF, 32'd0);
    access(4'd6, 32'h1C000101, 32'h12345678, 5'd0, 1'b0, 1, 1, 32'd0,        1'b1, 2'd0, 4'h2, 32'h78787878, 32'd0);
    access(4'd8, 32'h1C000300, 32'hCAFEF00D, 5'd0, 1'b0, 0, 0, 32'd0,        1'b1, 2'd2, 4'hF, 32'hCAFEF00D, 32'd0);
    access(4'd5, 32'h1C000202, 32'd0,        5'd5, 1'b1, 0, 2, 32'h80011234, 1'b0, 2'd1, 4'h0, 32'd0,        32'h00008001);
    access(4'd2, 32'h1C000202, 32'd0,        5'd6, 1'b1, 0, 0, 32'h80011234, 1'b0, 2'd1, 4'h0, 32'd0,        32'hFFFF8001);
    access(4'd2, 32'h1C000200, 32'd0,        5'd7, 1'b1, 1, 0, 32'h80011234, 1'b0, 2'd1, 4'h0, 32'd0,        32'h00001234);
    access(4'd1, 32'h1C000101, 32'd0,        5'd8, 1'b1, 0, 0, 32'h00007F00, 1'b0, 2'd0, 4'h0, 32'd0,        32'h0000007F);

    // Non-memory ops pass writeback straight through, including op 9.
    exp_wb.push_back('{rd: 5'd9, data: 32'h55AA55AA});
    drive(4'd0, 32'h0, 32'h0, 32'h55AA55AA, 5'd9, 1'b1);
    @(negedge clk);
    check("nop_pause", pause_req, 1'b0);
    tick();
    exp_wb.push_back('{rd: 5'd10, data: 32'h0F0F0F0F});
    drive(4'd9, 32'h1C000000, 32'h0, 32'h0F0F0F0F, 5'd10, 1'b1);
    @(negedge clk);
    check("op9_nop", {dbus.req, pause_req}, 2'b00);
    tick();
    nop();
    tick();

    // Misaligned accesses raise ALE without touching the bus.
    exp_ale.push_back(32'h1C000102);
    drive(4'd3, 32'h1C000102, 32'h0, 32'h0, 5'd3, 1'b1);
    @(negedge clk);
    check("ale_ldw", {ale_exception, dbus.req, pause_req}, 3'b100);
    tick();
    exp_ale.push_back(32'h1C000101);
    drive(4'd2, 32'h1C000101, 32'h0, 32'h0, 5'd3, 1'b1);
    @(negedge clk);
    check("ale_ldh", {ale_exception, dbus.req, pause_req}, 3'b100);
    tick();
    exp_ale.push_back(32'h1C000303);
    drive(4'd8, 32'h1C000303, 32'h11111111, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    check("ale_stw", {ale_exception, dbus.req, pause_req}, 3'b100);
    tick();
    exception_flush = 1'b1;
    drive(4'd3, 32'h1C000102, 32'h0, 32'h0, 5'd3, 1'b1);
    @(negedge clk);
    check("ale_flushed", {ale_exception, bad_vaddr}, 33'd0);
    tick();
    exception_flush = 1'b0;
    nop();
    @(negedge clk);
    check("ale_no_req", dbus.req, 1'b0);
    tick();

    // Flush during WAIT, next load must wait for the stale data_ok.
    exp_req.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h1C000400, wstrb: 4'h0, wdata: 32'd0});
    drive(4'd3, 32'h1C000400, 32'h0, 32'h0, 5'd11, 1'b1);
    tick();
    dbus.addr_ok = 1'b1;
    tick();
    dbus.addr_ok = 1'b0;
    exception_flush = 1'b1;
    tick();
    exception_flush = 1'b0;
    exp_req.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h1C000500, wstrb: 4'h0, wdata: 32'd0});
    exp_wb.push_back('{rd: 5'd12, data: 32'h0BADF00D});
    drive(4'd3, 32'h1C000500, 32'h0, 32'h0, 5'd12, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("drain_hold", {dbus.req, pause_req}, 2'b01);
      tick();
    end
    dbus.data_ok = 1'b1;
    dbus.rdata   = 32'hDEADBEEF;
    tick();
    dbus.data_ok = 1'b0;
    dbus.rdata   = 32'd0;
    @(negedge clk);
    check("drain_exit", {dbus.req, pause_req}, 2'b01);
    tick();
    check("new_req", dbus.req, 1'b1);
    dbus.addr_ok = 1'b1;
    tick();
    dbus.addr_ok = 1'b0;
    dbus.data_ok = 1'b1;
    dbus.rdata   = 32'h0BADF00D;
    tick();
    dbus.data_ok = 1'b0;
    dbus.rdata   = 32'd0;
    @(negedge clk);
    check("new_done_pause", pause_req, 1'b0);
    tick();
    nop();
    tick();

    // Flush in REQ withdraws the request.
    drive(4'd3, 32'h1C000600, 32'h0, 32'h0, 5'd13, 1'b1);
    tick();
    exception_flush = 1'b1;
    tick();
    exception_flush = 1'b0;
    nop();
    @(negedge clk);
    check("flush_req_drop", {dbus.req, pause_req}, 2'b00);
    tick();

    // Flush coinciding with data_ok: back to IDLE, data discarded.
    exp_req.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h1C000700, wstrb: 4'h0, wdata: 32'd0});
    drive(4'd3, 32'h1C000700, 32'h0, 32'h0, 5'd14, 1'b1);
    tick();
    dbus.addr_ok = 1'b1;
    tick();
    dbus.addr_ok = 1'b0;
    exception_flush = 1'b1;
    dbus.data_ok = 1'b1;
    dbus.rdata   = 32'h12345678;
    tick();
    exception_flush = 1'b0;
    dbus.data_ok = 1'b0;
    dbus.rdata   = 32'd0;
    access(4'd3, 32'h1C000800, 32'd0, 5'd15, 1'b1, 0, 0, 32'hA5A5C3C3, 1'b0, 2'd2, 4'h0, 32'd0, 32'hA5A5C3C3);
    tick();

    // Reset mid-transaction drops the request immediately.
    drive(4'd3, 32'h1C000900, 32'h0, 32'h0, 5'd16, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    check("rst_mid_req", dbus.req, 1'b0);
    nop();
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("rst_mid_idle", {dbus.req, pause_req}, 2'b00);
    tick();

    check("req_queue_empty", exp_req.size(), 0);
    check("wb_queue_empty",  exp_wb.size(),  0);
    check("ale_queue_empty", exp_ale.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
